// File: rtl/switch_pkg.sv
// switch_pkg: shared header field layout and ingress error codes
package switch_pkg;
  localparam int DEST_LSB = 0;
  localparam int PRIO_LSB = 4;
  localparam int LEN_LSB = 7;
  localparam int PORT_W = 4;
  localparam int PRIO_W = 3;
  localparam logic [1:0] ERR_OVF = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_SOP = 2'd2;
  localparam logic [1:0] ERR_ORPHAN = 2'd3;
endpackage

// File: rtl/ingress_ram.sv
// ingress_ram: simple dual-port beat store with registered, hold-when-idle read port
module ingress_ram #(
  parameter int AW = 6,
  parameter int W = 66
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // read register doubles as the output register, so it holds while stalled
  always_ff @(posedge clk) begin
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ingress_frame_checker.sv
// ingress_frame_checker: per-port framing check and commit-on-good FIFO; INGRESS_STATS_EN adds packet counters
module ingress_frame_checker
  import switch_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int AW = 6,
  parameter int LEN_W = 7,
  parameter int AF_THRESH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_sop,
  input  logic              wr_eop,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_data,
  output logic              out_vld,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_data,
  output logic [PORT_W-1:0] out_dest_port,
  output logic [PRIO_W-1:0] out_priority,
  output logic [LEN_W-1:0]  out_len,
  output logic              full,
  output logic              almost_full,
  output logic              drop,
  output logic [1:0]        err_code
`ifdef INGRESS_STATS_EN
  ,
  output logic [15:0]       pkt_ok_cnt,
  output logic [15:0]       pkt_drop_cnt
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;
  localparam logic [AW:0] AF_USED = (AW+1)'(2**AW - AF_THRESH);
  logic [1:0] st, st_n, err_n;
  logic [AW:0] wr_ptr, commit_ptr, rd_ptr, wr_n, cm_n, used, hused;
  logic [AW-1:0] waddr;
  logic [LEN_W-1:0] cnt, cnt_n, len, len_q;
  logic [PORT_W-1:0] dest_q;
  logic [PRIO_W-1:0] prio_q;
  logic [DATA_W+1:0] rdata;
  logic we, commit, drop_n, len_bad, empty, re;
  assign len = wr_data[LEN_LSB +: LEN_W];
  assign len_bad = wr_eop || len == '0;
  assign used = wr_ptr - rd_ptr;
  assign hused = commit_ptr - rd_ptr;
  assign full = used[AW];
  assign almost_full = used >= AF_USED;
  assign empty = rd_ptr == commit_ptr;
  assign re = !empty && (!out_vld || out_ready);
  assign waddr = wr_sop ? commit_ptr[AW-1:0] : wr_ptr[AW-1:0];
  assign out_data = rdata[DATA_W-1:0];
  assign out_sop = out_vld && rdata[DATA_W+1];
  assign out_eop = out_vld && rdata[DATA_W];
  assign out_dest_port = out_sop ? out_data[DEST_LSB +: PORT_W] : dest_q;
  assign out_priority = out_sop ? out_data[PRIO_LSB +: PRIO_W] : prio_q;
  assign out_len = out_sop ? out_data[LEN_LSB +: LEN_W] : len_q;
  // write-side framing FSM; a sop always restarts from commit_ptr, dropping any open packet
  always_comb begin
    st_n = st;
    wr_n = wr_ptr;
    cm_n = commit_ptr;
    cnt_n = cnt;
    we = 1'b0;
    commit = 1'b0;
    drop_n = 1'b0;
    err_n = ERR_OVF;
    if (wr_vld && wr_sop) begin
      drop_n = st == PAYLOAD || len_bad || hused[AW];
      err_n = st == PAYLOAD ? ERR_SOP : len_bad ? ERR_LEN : ERR_OVF;
      st_n = len_bad ? IDLE : hused[AW] ? DISCARD : PAYLOAD;
      we = !len_bad && !hused[AW];
      wr_n = we ? commit_ptr + 1'b1 : commit_ptr;
      cnt_n = len;
    end else if (wr_vld && st == PAYLOAD) begin
      we = !full;
      commit = !full && wr_eop && cnt == LEN_W'(1);
      drop_n = !commit && (full || wr_eop || cnt == LEN_W'(1));
      err_n = full ? ERR_OVF : ERR_LEN;
      st_n = (commit || (drop_n && wr_eop)) ? IDLE : drop_n ? DISCARD : PAYLOAD;
      wr_n = drop_n ? commit_ptr : wr_ptr + 1'b1;
      cm_n = commit ? wr_ptr + 1'b1 : commit_ptr;
      cnt_n = cnt - 1'b1;
    end else if (wr_vld) begin
      drop_n = st == IDLE;
      err_n = ERR_ORPHAN;
      st_n = wr_eop ? IDLE : DISCARD;
    end
  end
  // write-side state and drop reporting
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= IDLE;
      wr_ptr <= '0;
      commit_ptr <= '0;
      cnt <= '0;
      drop <= 1'b0;
      err_code <= '0;
    end else begin
      st <= st_n;
      wr_ptr <= wr_n;
      commit_ptr <= cm_n;
      cnt <= cnt_n;
      drop <= drop_n;
      err_code <= drop_n ? err_n : '0;
    end
  end
  // read side: fetch the next committed beat whenever the output register frees up
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      out_vld <= 1'b0;
    end else begin
      if (re) rd_ptr <= rd_ptr + 1'b1;
      out_vld <= re || (out_vld && !out_ready);
    end
  end
  // keep header fields of the presented packet until the next header appears
  always_ff @(posedge clk) begin
    if (!rst) begin
      dest_q <= '0;
      prio_q <= '0;
      len_q <= '0;
    end else if (out_sop) begin
      dest_q <= out_data[DEST_LSB +: PORT_W];
      prio_q <= out_data[PRIO_LSB +: PRIO_W];
      len_q <= out_data[LEN_LSB +: LEN_W];
    end
  end
`ifdef INGRESS_STATS_EN
  // saturating commit/drop counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_ok_cnt <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      if (commit && pkt_ok_cnt != '1) pkt_ok_cnt <= pkt_ok_cnt + 1'b1;
      if (drop_n && pkt_drop_cnt != '1) pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
    end
  end
`endif
  ingress_ram #(.AW(AW), .W(DATA_W+2)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(waddr),
    .wdata({wr_sop, wr_eop, wr_data}),
    .re(re),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );
endmodule
